// File: rtl/hex_keypad_entry.sv
// 5x4 matrix keypad scanner with debounce and a 4-digit hex entry register.
// Optional: define HEX_KEYPAD_AUTO_COMMIT_EN to commit automatically when the fourth digit lands.
module hex_keypad_entry #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [3:0]  Rows,
    output logic [4:0]  Cols,
    output logic [15:0] HEXIN,
    output logic        CNTRPIN,
    output logic [15:0] Entry,
    output logic [2:0]  Digits
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HOLD} state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       col, col_next, col_adv;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       key_row, key_row_next, row_low;
    logic             sample, idle, fire;

    logic [15:0] entry_next, hexin_next, shifted;
    logic [2:0]  digits_next;
    logic        strobe_next;

    assign sample  = (div_cnt == DIV_LAST);
    assign idle    = &Rows;
    assign col_adv = (col == 3'd4) ? 3'd0 : col + 3'd1;

    // Lowest asserted row wins when several keys in the column are down.
    always_comb begin
        row_low = 2'd0;
        for (int r = 3; r >= 0; r--)
            if (!Rows[r]) row_low = 2'(r);
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        col_next     = col;
        cnt_next     = cnt;
        key_row_next = key_row;
        fire         = 1'b0;
        if (sample) begin
            unique case (state)
                ST_SCAN: begin
                    if (idle) begin
                        col_next = col_adv;
                    end else begin
                        key_row_next = row_low;
                        if (DEBOUNCE == 1) begin
                            fire       = 1'b1;
                            state_next = ST_HOLD;
                            cnt_next   = '0;
                        end else begin
                            state_next = ST_DEBOUNCE;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!idle && row_low == key_row) begin
                        if (cnt == CNT_LAST) begin
                            fire       = 1'b1;
                            state_next = ST_HOLD;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end else begin
                        state_next = ST_SCAN;
                        col_next   = col_adv;
                    end
                end
                ST_HOLD: begin
                    if (!idle) begin
                        cnt_next = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = ST_SCAN;
                        col_next   = col_adv;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: state_next = ST_SCAN;
            endcase
        end
    end

    // Column is frozen outside SCAN, so the acting key is the current column and lowest row.
    always_comb begin
        entry_next  = Entry;
        digits_next = Digits;
        hexin_next  = HEXIN;
        strobe_next = 1'b0;
        shifted     = {Entry[11:0], row_low, col[1:0]};
        if (fire) begin
            if (col != 3'd4) begin
`ifdef HEX_KEYPAD_AUTO_COMMIT_EN
                if (Digits == 3'd3) begin
                    hexin_next  = shifted;
                    strobe_next = 1'b1;
                    entry_next  = '0;
                    digits_next = '0;
                end else begin
                    entry_next  = shifted;
                    digits_next = (Digits == 3'd4) ? 3'd4 : Digits + 3'd1;
                end
`else
                entry_next  = shifted;
                digits_next = (Digits == 3'd4) ? 3'd4 : Digits + 3'd1;
`endif
            end else begin
                unique case (row_low)
                    2'd0: begin
                        hexin_next  = Entry;
                        strobe_next = 1'b1;
                        entry_next  = '0;
                        digits_next = '0;
                    end
                    2'd1: begin
                        entry_next  = Entry >> 4;
                        digits_next = (Digits == 3'd0) ? 3'd0 : Digits - 3'd1;
                    end
                    2'd2: begin
                        entry_next  = '0;
                        digits_next = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state   <= ST_SCAN;
            div_cnt <= '0;
            col     <= 3'd0;
            Cols    <= 5'b11110;
            cnt     <= '0;
            key_row <= 2'd0;
            Entry   <= '0;
            Digits  <= '0;
            HEXIN   <= '0;
            CNTRPIN <= 1'b0;
        end else begin
            state   <= state_next;
            div_cnt <= sample ? '0 : div_cnt + DIV_W'(1);
            col     <= col_next;
            Cols    <= ~(5'd1 << col_next);
            cnt     <= cnt_next;
            key_row <= key_row_next;
            Entry   <= entry_next;
            Digits  <= digits_next;
            HEXIN   <= hexin_next;
            CNTRPIN <= strobe_next;
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: a keypad model driving Rows from Cols, and a key-level
// model of entry/commit behaviour; define HEX_KEYPAD_AUTO_COMMIT_EN to exercise auto-commit.
module tb_hex_keypad_entry;

    localparam int S = 4;
    localparam int D = 3;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic [3:0]  Rows;
    logic [4:0]  Cols;
    logic [15:0] HEXIN;
    logic        CNTRPIN;
    logic [15:0] Entry;
    logic [2:0]  Digits;

    logic [19:0] pressed = '0;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_entry = '0;
    logic [15:0] m_hexin = '0;
    int          m_digits = 0;
    int          m_pulses = 0;

    int          pulse_cnt = 0;
    int          long_pulses = 0;
    int          cycle = 0;
    int          last_pulse = -1000;
    int          min_gap = 1000000;
    int          cols_bad = 0;
    logic        prev_strobe = 1'b0;
    logic [15:0] pulse_hexin = '0;

    hex_keypad_entry #(.SCAN_DIV(S), .DEBOUNCE(D)) dut (
        .Clk(Clk), .Clr(Clr), .Rows(Rows), .Cols(Cols),
        .HEXIN(HEXIN), .CNTRPIN(CNTRPIN), .Entry(Entry), .Digits(Digits)
    );

    always #5 Clk = ~Clk;

    // Passive keypad: a pressed key shorts its row to the driven (low) column.
    always_comb begin
        Rows = 4'hF;
        for (int c = 0; c < 5; c++)
            if (Cols[c] == 1'b0)
                for (int r = 0; r < 4; r++)
                    if (pressed[c*4 + r]) Rows[r] = 1'b0;
    end

    always @(negedge Clk) begin
        cycle++;
        if (!Clr && $countones(~Cols) != 1) cols_bad++;
        if (CNTRPIN === 1'b1) begin
            pulse_cnt++;
            pulse_hexin = HEXIN;
            if (prev_strobe) long_pulses++;
            else begin
                if (cycle - last_pulse < min_gap) min_gap = cycle - last_pulse;
                last_pulse = cycle;
            end
        end
        prev_strobe = (CNTRPIN === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic model_commit(input logic [15:0] w);
        m_hexin  = w;
        m_pulses++;
        m_entry  = '0;
        m_digits = 0;
    endtask

    task automatic model_reset();
        m_entry  = '0;
        m_digits = 0;
        m_hexin  = '0;
    endtask

    task automatic model_key(input int c, input int r);
        logic [15:0] w;
        if (c < 4) begin
            w = {m_entry[11:0], 4'(r*4 + c)};
`ifdef HEX_KEYPAD_AUTO_COMMIT_EN
            if (m_digits == 3) model_commit(w);
            else begin
                m_entry  = w;
                m_digits = (m_digits < 4) ? m_digits + 1 : 4;
            end
`else
            m_entry  = w;
            m_digits = (m_digits < 4) ? m_digits + 1 : 4;
`endif
        end else begin
            case (r)
                0: model_commit(m_entry);
                1: begin
                    m_entry  = m_entry >> 4;
                    m_digits = (m_digits > 0) ? m_digits - 1 : 0;
                end
                2: begin
                    m_entry  = '0;
                    m_digits = 0;
                end
                default: ;
            endcase
        end
    endtask

    // Returns right after Cols switches onto column c, i.e. at the start of its dwell.
    task automatic wait_col_start(input int c);
        logic [4:0] tgt;
        int n;
        tgt = ~(5'd1 << c);
        n = 0;
        while (Cols == tgt && n < 200) begin @(negedge Clk); n++; end
        while (Cols != tgt && n < 200) begin @(negedge Clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_col%0d: timeout, Cols=%b required %b", c, Cols, tgt);
        end
    endtask

    task automatic press(input int c, input int r, input int hold, input int rel, input int extra_row);
        pressed[c*4 + r] = 1'b1;
        if (extra_row >= 0) pressed[c*4 + extra_row] = 1'b1;
        idle(hold);
        pressed = '0;
        idle(rel);
        model_key(c, r);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (Cols !== 5'b11110) begin errors++; $display("FAIL reset_cols: got %b required 11110", Cols); end
        checks++; if (HEXIN !== 16'h0) begin errors++; $display("FAIL reset_hexin: got %h required 0000", HEXIN); end
        checks++; if (Entry !== 16'h0) begin errors++; $display("FAIL reset_entry: got %h required 0000", Entry); end
        checks++; if (Digits !== 3'd0) begin errors++; $display("FAIL reset_digits: got %0d required 0", Digits); end
        checks++; if (CNTRPIN !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b required 0", CNTRPIN); end
        @(negedge Clk);
        Clr = 1'b0;
        idle(S - 1);
        checks++; if (Cols !== 5'b11110) begin errors++; $display("FAIL dwell_hold: got %b required 11110", Cols); end
        idle(1);
        checks++; if (Cols !== 5'b11101) begin errors++; $display("FAIL dwell_adv: got %b required 11101", Cols); end
    endtask

    task automatic test_basic_entry();
        wait_col_start(1);
        pressed[1*4 + 0] = 1'b1;
        idle(S + (D - 1)*S - 1);
        checks++; if (Digits !== 3'd0) begin errors++; $display("FAIL latency_early: digits got %0d required 0", Digits); end
        idle(1);
        checks++; if (Entry !== 16'h0001 || Digits !== 3'd1) begin
            errors++; $display("FAIL latency_on_time: entry/digits got %h/%0d required 0001/1", Entry, Digits); end
        idle(10);
        pressed = '0;
        idle(25);
        model_key(1, 0);
        press(2, 0, 45, 25, -1);
        press(3, 0, 45, 25, -1);
        press(0, 1, 45, 25, -1);
        press(4, 0, 45, 25, -1);
`ifndef HEX_KEYPAD_AUTO_COMMIT_EN
        checks++; if (HEXIN !== 16'h1234) begin errors++; $display("FAIL basic_hexin_const: got %h required 1234", HEXIN); end
`endif
        checks++; if (HEXIN !== m_hexin) begin errors++; $display("FAIL basic_hexin: got %h required %h", HEXIN, m_hexin); end
        checks++; if (pulse_cnt !== m_pulses || long_pulses !== 0) begin
            errors++; $display("FAIL basic_strobe: pulses %0d long %0d required %0d long 0", pulse_cnt, long_pulses, m_pulses); end
        checks++; if (pulse_hexin !== m_hexin) begin errors++; $display("FAIL basic_strobe_hexin: got %h required %h", pulse_hexin, m_hexin); end
        checks++; if (Entry !== 16'h0 || Digits !== 3'd0) begin
            errors++; $display("FAIL basic_cleared: entry/digits got %h/%0d required 0000/0", Entry, Digits); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 5; k++) press(k % 4, k / 4, 45, 25, -1);
`ifndef HEX_KEYPAD_AUTO_COMMIT_EN
        checks++; if (Entry !== 16'h2345 || Digits !== 3'd4) begin
            errors++; $display("FAIL overflow_const: entry/digits got %h/%0d required 2345/4", Entry, Digits); end
`endif
        checks++; if (Entry !== m_entry || Digits !== 3'(m_digits) || pulse_cnt !== m_pulses) begin
            errors++; $display("FAIL overflow: entry/digits/pulses got %h/%0d/%0d required %h/%0d/%0d",
                               Entry, Digits, pulse_cnt, m_entry, m_digits, m_pulses); end
        press(4, 1, 45, 25, -1);
        checks++; if (Entry !== m_entry || Digits !== 3'(m_digits)) begin
            errors++; $display("FAIL backspace: entry/digits got %h/%0d required %h/%0d", Entry, Digits, m_entry, m_digits); end
        press(4, 3, 45, 25, -1);
        checks++; if (Entry !== m_entry || Digits !== 3'(m_digits)) begin
            errors++; $display("FAIL noop_key: entry/digits got %h/%0d required %h/%0d", Entry, Digits, m_entry, m_digits); end
        press(4, 2, 45, 25, -1);
        checks++; if (Entry !== 16'h0 || Digits !== 3'd0 || HEXIN !== m_hexin || pulse_cnt !== m_pulses) begin
            errors++; $display("FAIL clear_key: entry/digits/hexin/pulses got %h/%0d/%h/%0d required 0000/0/%h/%0d",
                               Entry, Digits, HEXIN, pulse_cnt, m_hexin, m_pulses); end
    endtask

    task automatic test_bounce();
        wait_col_start(3);
        pressed[3*4 + 1] = 1'b1;
        idle(S);
        pressed = '0;
        idle(S);
        checks++; if (Cols !== 5'b01111) begin errors++; $display("FAIL bounce_resume: Cols got %b required 01111", Cols); end
        idle(30);
        checks++; if (Entry !== m_entry || Digits !== 3'(m_digits)) begin
            errors++; $display("FAIL bounce_no_action: entry/digits got %h/%0d required %h/%0d", Entry, Digits, m_entry, m_digits); end
    endtask

    task automatic test_long_hold();
        int n, bad;
        n = 0;
        bad = 0;
        pressed[2*4 + 2] = 1'b1;
        while (Digits === 3'(m_digits) && n < 60) begin @(negedge Clk); n++; end
        checks++; if (n >= 60) begin errors++; $display("FAIL hold_detect: no action within 60 cycles, digits %0d", Digits); end
        repeat (50*S) begin
            @(negedge Clk);
            if (Cols !== 5'b11011 || Entry !== 16'h000A || Digits !== 3'd1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_frozen: %0d bad cycles required 0", bad); end
        pressed = '0;
        model_key(2, 2);
        idle(2*S);
        checks++; if (Cols !== 5'b11011) begin errors++; $display("FAIL hold_release_early: Cols got %b required 11011", Cols); end
        idle(S);
        checks++; if (Cols !== 5'b10111) begin errors++; $display("FAIL hold_release: Cols got %b required 10111", Cols); end
        checks++; if (Entry !== 16'h000A || Digits !== 3'd1) begin
            errors++; $display("FAIL hold_once: entry/digits got %h/%0d required 000A/1", Entry, Digits); end
        idle(20);
    endtask

    task automatic test_reset_mid_op();
        int n;
        press(3, 2, 45, 25, -1);
        checks++; if (Entry !== 16'h00AB) begin errors++; $display("FAIL pre_reset_entry: got %h required 00AB", Entry); end
        wait_col_start(1);
        pressed[1*4 + 1] = 1'b1;
        idle(S + 2);
        #1 Clr = 1'b1;
        #1;
        checks++; if (Cols !== 5'b11110 || Entry !== 16'h0 || Digits !== 3'd0 || HEXIN !== 16'h0 || CNTRPIN !== 1'b0) begin
            errors++; $display("FAIL mid_debounce_reset: cols/entry/digits/hexin/strobe got %b/%h/%0d/%h/%b required 11110/0000/0/0000/0",
                               Cols, Entry, Digits, HEXIN, CNTRPIN); end
        pressed = '0;
        model_reset();
        @(negedge Clk);
        Clr = 1'b0;
        idle(60);
        checks++; if (Entry !== 16'h0 || Digits !== 3'd0 || pulse_cnt !== m_pulses) begin
            errors++; $display("FAIL post_reset_quiet: entry/digits/pulses got %h/%0d/%0d required 0000/0/%0d",
                               Entry, Digits, pulse_cnt, m_pulses); end
        press(3, 1, 45, 25, -1);
        pressed[4*4 + 0] = 1'b1;
        n = 0;
        while (CNTRPIN !== 1'b1 && n < 60) begin @(negedge Clk); n++; end
        model_key(4, 0);
        checks++; if (CNTRPIN !== 1'b1 || HEXIN !== m_hexin) begin
            errors++; $display("FAIL enter_coincide: strobe/hexin got %b/%h required 1/%h", CNTRPIN, HEXIN, m_hexin); end
        #1 Clr = 1'b1;
        #1;
        checks++; if (CNTRPIN !== 1'b0 || HEXIN !== 16'h0) begin
            errors++; $display("FAIL strobe_reset: strobe/hexin got %b/%h required 0/0000", CNTRPIN, HEXIN); end
        pressed = '0;
        model_reset();
        @(negedge Clk);
        Clr = 1'b0;
        idle(30);
    endtask

`ifdef HEX_KEYPAD_AUTO_COMMIT_EN
    task automatic test_auto_commit();
        int n;
        press(0, 3, 45, 25, -1);
        press(2, 2, 45, 25, -1);
        press(3, 3, 45, 25, -1);
        pressed[2*4 + 3] = 1'b1;
        n = 0;
        while (CNTRPIN !== 1'b1 && n < 60) begin @(negedge Clk); n++; end
        checks++; if (CNTRPIN !== 1'b1 || HEXIN !== 16'hCAFE || Digits !== 3'd0 || Entry !== 16'h0) begin
            errors++; $display("FAIL auto_commit: strobe/hexin/digits/entry got %b/%h/%0d/%h required 1/CAFE/0/0000",
                               CNTRPIN, HEXIN, Digits, Entry); end
        idle(20);
        pressed = '0;
        idle(25);
        model_key(2, 3);
    endtask
`endif

    task automatic test_random();
        int c, r, r2;
        for (int it = 0; it < 25; it++) begin
            c  = $urandom_range(0, 4);
            r  = $urandom_range(0, 3);
            r2 = -1;
            if (r < 3 && $urandom_range(0, 4) == 0) r2 = $urandom_range(r + 1, 3);
            press(c, r, $urandom_range(40, 70), $urandom_range(20, 30), r2);
            checks++; if (Entry !== m_entry || Digits !== 3'(m_digits) || HEXIN !== m_hexin) begin
                errors++; $display("FAIL rand%0d key c%0d r%0d: entry/digits/hexin got %h/%0d/%h required %h/%0d/%h",
                                   it, c, r, Entry, Digits, HEXIN, m_entry, m_digits, m_hexin); end
            checks++; if (pulse_cnt !== m_pulses || long_pulses !== 0) begin
                errors++; $display("FAIL rand%0d strobe: pulses %0d long %0d required %0d long 0", it, pulse_cnt, long_pulses, m_pulses); end
        end
        checks++; if (min_gap < 2*D*S) begin errors++; $display("FAIL strobe_gap: got %0d required >= %0d", min_gap, 2*D*S); end
        checks++; if (cols_bad != 0) begin errors++; $display("FAIL cols_onehot: %0d bad cycles required 0", cols_bad); end
    endtask

    initial begin
        #2 Clr = 1'b1;
        test_reset();
        test_basic_entry();
        test_overflow();
        test_bounce();
        test_long_hold();
        test_reset_mid_op();
`ifdef HEX_KEYPAD_AUTO_COMMIT_EN
        test_auto_commit();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_keypad_entry.md
# hex_keypad_entry

Scans a 5-column × 4-row matrix keypad, debounces key presses, and assembles up to four hex digits into a 16-bit entry word. On Enter it commits the word to `HEXIN` and pulses `CNTRPIN` for one cycle. It sits directly upstream of the CPU's hex input encoder, which latches `HEXIN` whenever `CNTRPIN` is high. `Entry` and `Digits` give the live, uncommitted value for a display.

## Interface
- `SCAN_DIV`, default 4: clock cycles each column is driven (dwell); must be ≥2.
- `DEBOUNCE`, default 3: consecutive matching samples required for press and for release; must be ≥1.
- `Clk` in 1: clock, rising-edge.
- `Clr` in 1: reset, asynchronous, active-high.
- `Rows` in 4: keypad row sense, active-low, externally synchronised.
- `Cols` out 5: column drive, active-low, exactly one bit low.
- `HEXIN` out 16: last committed word, held until the next commit.
- `CNTRPIN` out 1: one-cycle commit strobe.
- `Entry` out 16: working entry register.
- `Digits` out 3: digits entered, 0–4.

## Operation
- Key map for columns 0–3: digit = row·4 + col. For example, col1/row0 = 1 and col3/row3 = F.
- Column 4: row0 = Enter, row1 = Backspace, row2 = Clear, row3 = no-op.
- Dwell counter: 0..SCAN_DIV-1. `Rows` is sampled only on the cycle where the counter = SCAN_DIV-1 (the sample point).
- Several rows low in one sample: the lowest row index wins.
- FSM states:
  - SCAN: advances the column 0→1→2→3→4→0 after each sample with `Rows`=4'hF. On any row low: latch {col,row}, set the match count to 1, and go to DEBOUNCE on the same column. With DEBOUNCE=1, the key action happens in that cycle and the FSM goes to HOLD.
  - DEBOUNCE: column frozen. A sample with the same key increments the match count. When the count reaches DEBOUNCE, execute the key action and go to HOLD. Any other sample returns to SCAN and advances to the next column.
  - HOLD: column frozen. DEBOUNCE consecutive samples with `Rows`=4'hF return to SCAN at the next column. Any non-idle sample resets the release count. A held key therefore acts exactly once; there is no autorepeat.
- Key actions (all take effect in one cycle):
  - Digit d: `Entry` ← {Entry[11:0], d}; `Digits` ← min(Digits+1, 4). The oldest digit is lost on overflow.
  - Backspace: `Entry` ← Entry >> 4; `Digits` ← max(Digits−1, 0).
  - Clear: `Entry` ← 0; `Digits` ← 0; `HEXIN` unchanged; no strobe.
  - Enter: `HEXIN` ← Entry; `CNTRPIN` ← 1 for one cycle; `Entry` ← 0; `Digits` ← 0. Enter with `Digits`=0 still commits 0x0000.
  - Col4/row3: no action, but it still goes through HOLD.
- Keys in other columns are invisible while in DEBOUNCE or HOLD. A key still down after the release is found on a later scan.

## Timing
- Reset values:
  - `Cols` = 5'b11110 (column 0).
  - Dwell counter = 0, FSM = SCAN.
  - `HEXIN`, `Entry` = 0; `Digits` = 0; `CNTRPIN` = 0.
- Clr is asynchronous and overrides everything, including mid-DEBOUNCE, mid-HOLD, or the `CNTRPIN` cycle. The strobe drops immediately and no partial action survives.
- All outputs are registered. `Cols` changes only on the cycle after a sample point.
- Press latency: the action is registered on the clock edge of the DEBOUNCE-th matching sample. That is (DEBOUNCE−1)·SCAN_DIV cycles after first detection.
- `CNTRPIN` high coincides with the new `HEXIN` value. `HEXIN` stays stable afterwards, so the downstream encoder latches the correct value on that edge.
- The minimum interval between two `CNTRPIN` pulses is 2·DEBOUNCE·SCAN_DIV cycles.

## Configuration
- `HEX_KEYPAD_AUTO_COMMIT_EN`:
  - Defined: a digit key that makes `Digits` reach 4 also performs the Enter action in the same cycle: `HEXIN` ← the new 4-digit word, `CNTRPIN` pulses, `Entry`/`Digits` clear. Enter still works for shorter entries.
  - Undefined: digits only accumulate; commit happens on Enter only.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3, macro undefined unless noted.
- **Basic entry:** press 1, 2, 3, 4, Enter, each held ≥3 samples and released ≥3 samples → `HEXIN`=0x1234, exactly one 1-cycle `CNTRPIN`; then `Entry`=0, `Digits`=0.
- **Overflow:** press 1, 2, 3, 4, 5 → `Entry`=0x2345, `Digits`=4, no strobe. Then Backspace → `Entry`=0x0234, `Digits`=3.
- **Bounce:** key 7 low for 1 sample then high → no change to `Entry`/`Digits`; the scan resumes at the next column.
- **Long hold:** hold key A for 50 samples → `Entry`=0x000A and `Digits`=1 exactly once. `Cols` stays frozen on column 2 until 3 idle samples.
- **Reset mid-operation:** Clr asserted during DEBOUNCE with `Entry`=0x00AB → all outputs at reset values immediately; no action after Clr releases.
- **Auto-commit:** with `HEX_KEYPAD_AUTO_COMMIT_EN` defined, press C, A, F, E → `CNTRPIN` pulses on the E action, `HEXIN`=0xCAFE, `Digits`=0.
